id_alu_decode: RTL and testbench
================================

ID_ALU_DECODE -- requirements
Module: id_alu_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port instr_i, input, 32 bits: RV32I instruction from the IF/ID stage.
REQ-004 SHALL have port pc_i, input, 32 bits: PC of instr_i.
REQ-005 SHALL have port valid_i, input, 1 bit: instr_i/pc_i hold a real instruction.
REQ-006 SHALL have port stall, input, 1 bit: hold the ID/EX register.
REQ-007 SHALL have port flush, input, 1 bit: replace the ID/EX contents with a bubble.
REQ-008 SHALL have port ALUCode, output, 4 bits: registered ALU operation select.
REQ-009 SHALL have port imm_o, output, 32 bits: registered, sign-extended immediate.
REQ-010 SHALL have port ALUSrcA, output, 1 bit: 0 selects rs1, 1 selects PC.
REQ-011 SHALL have port ALUSrcB, output, 1 bit: 0 selects rs2, 1 selects imm_o.
REQ-012 SHALL have port pc_o, output, 32 bits: registered copy of pc_i.
REQ-013 SHALL have port valid_o, output, 1 bit: the ID/EX register holds a real instruction.
REQ-014 SHALL have port illegal_o, output, 1 bit: the registered instruction is not decodable.

Function
REQ-015 ALUCode encodings SHALL be: add=0, sub=1, lui=2, and=3, xor=4, or=5, sll=6, srl=7, sra=8, slt=9, sltu=10.
REQ-016 Decode is combinational from instr_i; every output SHALL be registered, giving 1-cycle latency from instr_i to the outputs.
REQ-017 Opcode 0110011 (R-type) SHALL map on funct3/funct7[5] to add/sub/sll/slt/sltu/xor/srl/sra/or/and, with ALUSrcB=0.
REQ-018 Opcode 0010011 (I-type ALU) SHALL map the same way with ALUSrcB=1.
  - funct7[5] is ignored except for shifts; addi never decodes as sub.
  - For slli/srli/srai, imm_o SHALL be zero-extended instr[24:20]; range 0-31.
REQ-019 LUI SHALL decode as: ALUCode=lui, ALUSrcB=1, imm_o={instr[31:12],12'b0}.
REQ-020 AUIPC SHALL decode as: add, ALUSrcA=1, ALUSrcB=1, imm_o=U-immediate.
REQ-021 LOAD and STORE SHALL decode as: add, ALUSrcB=1, imm_o=I-immediate or S-immediate respectively.
REQ-022 BRANCH SHALL decode as: sub, ALUSrcA=0, ALUSrcB=0, imm_o=B-immediate.
REQ-023 JAL and JALR SHALL decode as: add, ALUSrcA=1, ALUSrcB=1, imm_o=32'd4 (link value).
REQ-024 On each edge, register update priority SHALL be: flush > stall > load.
  - flush=1: load the bubble (valid_o=0, ALUCode=add, imm_o=0, ALUSrcA=0, ALUSrcB=0, illegal_o=0, pc_o=0).
  - stall=1 and flush=0: all outputs hold their values.
  - Otherwise: load the decoded values; valid_o=valid_i.
REQ-025 With valid_i=0 and no stall or flush, the register SHALL load the bubble.
REQ-026 Simultaneous stall and flush SHALL produce the bubble.

Reset
REQ-027 rst_n=0 at an edge SHALL load the bubble values of REQ-024 and override stall, flush and valid_i.
REQ-028 Reset asserted mid-stream SHALL discard the held instruction; the first valid_o=1 SHALL appear one edge after rst_n=1 with valid_i=1.

Configuration
REQ-029 Macro ILLEGAL_TRAP_EN SHALL control illegal-instruction detection.
  - Defined: an unknown opcode, or an unknown funct3/funct7 combination for R-type or shifts, SHALL set illegal_o=1 with valid_o=1 and ALUCode=add.
  - Undefined: illegal_o SHALL be constant 0 and unknown encodings SHALL decode as add with ALUSrcB=0.

Structure
REQ-030 The ALUCode localparams, RV32I opcode constants and bubble defaults SHALL live in a shared package used by both this block and the ALU.
REQ-031 The immediate generator SHALL be one combinational sub-module, imm_gen, that selects the I/S/B/U/shamt formats.

Verification
REQ-032 0x00500093 (addi x1,x0,5), valid_i=1 -> next edge: ALUCode=0, imm_o=5, ALUSrcB=1, valid_o=1.
REQ-033 0x402081B3 (sub) -> ALUCode=1, ALUSrcB=0; 0x40335293 (srai) -> ALUCode=8, imm_o=3.
REQ-034 0x123453B7 (lui) -> ALUCode=2, imm_o=0x12345000; 0x0020A423 (sw) -> ALUCode=0, imm_o=8.
REQ-035 Load addi, then assert stall for 3 cycles with sub on instr_i -> outputs stay addi; release -> sub appears next edge.
REQ-036 stall=1 and flush=1 together -> valid_o=0, ALUCode=0; rst_n=0 mid-stall -> bubble on that edge.
REQ-037 0xFFFFFFFF -> illegal_o=1 with ILLEGAL_TRAP_EN defined, illegal_o=0 without it.

Source files
------------

// File: rtl/id_alu_decode_pkg.sv
// Shared ALU operation codes, RV32I opcodes and ID/EX register layout,
// used by the decode stage and by the ALU.
package id_alu_decode_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_LUI  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_ZERO,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_SHAMT,
        IMM_LINK
    } imm_sel_e;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [3:0]  alu_code;
        logic [31:0] imm;
        logic        src_a;
        logic        src_b;
        logic [31:0] pc;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '{
        valid:    1'b0,
        illegal:  1'b0,
        alu_code: ALU_ADD,
        imm:      32'd0,
        src_a:    1'b0,
        src_b:    1'b0,
        pc:       32'd0
    };

    // alt distinguishes sub from add and sra from srl; callers decide when it applies.
    function automatic logic [3:0] funct3_to_alu(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_alu_decode_imm_gen.sv
// Combinational RV32I immediate generator: I/S/B/U formats, shift amount
// and the constant 4 used as the jump link value.
module imm_gen
    import id_alu_decode_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_sel_e    sel,
    output logic [31:0] imm
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        imm = 32'd0;
        case (sel)
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'b0};
            IMM_SHAMT: imm = {27'b0, instr[24:20]};
            IMM_LINK:  imm = 32'd4;
            default:   imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_alu_decode.sv
// RV32I decode stage feeding a registered ID/EX ALU control word.
// Define ILLEGAL_TRAP_EN to report undecodable instructions on illegal_o.
module id_alu_decode
    import id_alu_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        valid_i,
    input  logic        stall,
    input  logic        flush,
    output logic [3:0]  ALUCode,
    output logic [31:0] imm_o,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_shift;
    logic        illegal;
    logic [3:0]  alu_code;
    logic        src_a;
    logic        src_b;
    imm_sel_e    imm_sel;
    logic [31:0] imm;
    idex_t       dec;
    idex_t       q;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        alu_code = ALU_ADD;
        src_a    = 1'b0;
        src_b    = 1'b0;
        imm_sel  = IMM_ZERO;
        illegal  = 1'b0;
        case (opcode)
            OP_R: begin
                alu_code = funct3_to_alu(funct3, funct7[5]);
                illegal  = (funct7 != FUNCT7_BASE) &&
                           !((funct7 == FUNCT7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OP_I: begin
                // Bit 30 is immediate data for addi etc.; it only selects srai.
                alu_code = funct3_to_alu(funct3, (funct3 == 3'b101) && funct7[5]);
                src_b    = 1'b1;
                imm_sel  = is_shift ? IMM_SHAMT : IMM_I;
                illegal  = is_shift && (funct7 != FUNCT7_BASE) &&
                           !((funct7 == FUNCT7_ALT) && (funct3 == 3'b101));
            end
            OP_LUI: begin
                alu_code = ALU_LUI;
                src_b    = 1'b1;
                imm_sel  = IMM_U;
            end
            OP_AUIPC: begin
                src_a   = 1'b1;
                src_b   = 1'b1;
                imm_sel = IMM_U;
            end
            OP_LOAD: begin
                src_b   = 1'b1;
                imm_sel = IMM_I;
            end
            OP_STORE: begin
                src_b   = 1'b1;
                imm_sel = IMM_S;
            end
            OP_BRANCH: begin
                alu_code = ALU_SUB;
                imm_sel  = IMM_B;
            end
            OP_JAL, OP_JALR: begin
                src_a   = 1'b1;
                src_b   = 1'b1;
                imm_sel = IMM_LINK;
            end
            default: illegal = 1'b1;
        endcase

        // Anything undecodable becomes a plain rs1+rs2 add, trap or not.
        if (illegal) begin
            alu_code = ALU_ADD;
            src_a    = 1'b0;
            src_b    = 1'b0;
            imm_sel  = IMM_ZERO;
        end
    end

    imm_gen u_imm_gen (
        .instr (instr_i[31:7]),
        .sel   (imm_sel),
        .imm   (imm)
    );

    always_comb begin
        dec          = IDEX_BUBBLE;
        dec.valid    = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        dec.illegal  = illegal;
`else
        dec.illegal  = 1'b0;
`endif
        dec.alu_code = alu_code;
        dec.imm      = imm;
        dec.src_a    = src_a;
        dec.src_b    = src_b;
        dec.pc       = pc_i;
    end

    // Priority: reset, then flush, then stall (hold), then load.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
        if (!rst_n || flush) begin
            q <= IDEX_BUBBLE;
        end else if (!stall) begin
            q <= valid_i ? dec : IDEX_BUBBLE;
        end
    end

    assign ALUCode   = q.alu_code;
    assign imm_o     = q.imm;
    assign ALUSrcA   = q.src_a;
    assign ALUSrcB   = q.src_b;
    assign pc_o      = q.pc;
    assign valid_o   = q.valid;
    assign illegal_o = q.illegal;

endmodule

// File: tb/tb_id_alu_decode.sv
// Directed, table-driven bench for id_alu_decode plus stall/flush/reset sequences.
module tb_id_alu_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        stall;
    logic        flush;
    logic [3:0]  ALUCode;
    logic [31:0] imm_o;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        illegal_o;

    int checks   = 0;
    int failures = 0;

`ifdef ILLEGAL_TRAP_EN
    localparam bit EXP_ILL = 1'b1;
`else
    localparam bit EXP_ILL = 1'b0;
`endif

    localparam logic [31:0] ADDI_X1_5 = 32'h00500093;
    localparam logic [31:0] SUB_X3    = 32'h402081B3;

    id_alu_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_i   (instr_i),
        .pc_i      (pc_i),
        .valid_i   (valid_i),
        .stall     (stall),
        .flush     (flush),
        .ALUCode   (ALUCode),
        .imm_o     (imm_o),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .pc_o      (pc_o),
        .valid_o   (valid_o),
        .illegal_o (illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu;
        logic [31:0] imm;
        bit          chk_imm;
        bit          src_a;
        bit          src_b;
        bit          ill;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %0s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string name);
        check({name, ".valid"},   {31'd0, valid_o},   32'd0);
        check({name, ".alu"},     {28'd0, ALUCode},   32'd0);
        check({name, ".imm"},     imm_o,              32'd0);
        check({name, ".src_a"},   {31'd0, ALUSrcA},   32'd0);
        check({name, ".src_b"},   {31'd0, ALUSrcB},   32'd0);
        check({name, ".illegal"}, {31'd0, illegal_o}, 32'd0);
        check({name, ".pc"},      pc_o,               32'd0);
    endtask

    task automatic check_addi(input string name, input logic [31:0] pc);
        check({name, ".valid"}, {31'd0, valid_o}, 32'd1);
        check({name, ".alu"},   {28'd0, ALUCode}, 32'd0);
        check({name, ".imm"},   imm_o,            32'd5);
        check({name, ".src_b"}, {31'd0, ALUSrcB}, 32'd1);
        check({name, ".pc"},    pc_o,             pc);
    endtask

    initial begin
        //             instr          alu    imm           chk a  b  ill
        vecs[0]  = '{32'h00500093, 4'd0,  32'h00000005, 1, 0, 1, 0};        // addi x1,x0,5
        vecs[1]  = '{32'h402081B3, 4'd1,  32'h00000000, 0, 0, 0, 0};        // sub
        vecs[2]  = '{32'h40335293, 4'd8,  32'h00000003, 1, 0, 1, 0};        // srai
        vecs[3]  = '{32'h123453B7, 4'd2,  32'h12345000, 1, 0, 1, 0};        // lui
        vecs[4]  = '{32'h0020A423, 4'd0,  32'h00000008, 1, 0, 1, 0};        // sw 8(x1)
        vecs[5]  = '{32'h00001097, 4'd0,  32'h00001000, 1, 1, 1, 0};        // auipc x1,1
        vecs[6]  = '{32'hFE000CE3, 4'd1,  32'hFFFFFFF8, 1, 0, 0, 0};        // beq -8
        vecs[7]  = '{32'h010000EF, 4'd0,  32'h00000004, 1, 1, 1, 0};        // jal
        vecs[8]  = '{32'h00008067, 4'd0,  32'h00000004, 1, 1, 1, 0};        // jalr
        vecs[9]  = '{32'hFFC12283, 4'd0,  32'hFFFFFFFC, 1, 0, 1, 0};        // lw -4(x2)
        vecs[10] = '{32'h4020D1B3, 4'd8,  32'h00000000, 0, 0, 0, 0};        // sra
        vecs[11] = '{32'hFFF13093, 4'd10, 32'hFFFFFFFF, 1, 0, 1, 0};        // sltiu -1
        vecs[12] = '{32'h40000093, 4'd0,  32'h00000400, 1, 0, 1, 0};        // addi bit30 set
        vecs[13] = '{32'h01F09093, 4'd6,  32'h0000001F, 1, 0, 1, 0};        // slli 31
        vecs[14] = '{32'h003120B3, 4'd9,  32'h00000000, 0, 0, 0, 0};        // slt
        vecs[15] = '{32'h003160B3, 4'd5,  32'h00000000, 0, 0, 0, 0};        // or
        vecs[16] = '{32'hFFFFFFFF, 4'd0,  32'h00000000, 0, 0, 0, EXP_ILL};  // unknown opcode
        vecs[17] = '{32'h022080B3, 4'd0,  32'h00000000, 0, 0, 0, EXP_ILL};  // mul funct7

        // Reset overrides a valid instruction with stall/flush low.
        rst_n   = 1'b0;
        instr_i = ADDI_X1_5;
        pc_i    = 32'h0000_0040;
        valid_i = 1'b1;
        stall   = 1'b0;
        flush   = 1'b0;
        step();
        check_bubble("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            instr_i = vecs[i].instr;
            pc_i    = 32'h1000 + 32'(i) * 4;
            step();
            check($sformatf("vec%0d.valid", i),   {31'd0, valid_o},   32'd1);
            check($sformatf("vec%0d.alu", i),     {28'd0, ALUCode},   {28'd0, vecs[i].alu});
            if (vecs[i].chk_imm)
                check($sformatf("vec%0d.imm", i), imm_o,              vecs[i].imm);
            check($sformatf("vec%0d.src_a", i),   {31'd0, ALUSrcA},   {31'd0, vecs[i].src_a});
            check($sformatf("vec%0d.src_b", i),   {31'd0, ALUSrcB},   {31'd0, vecs[i].src_b});
            check($sformatf("vec%0d.illegal", i), {31'd0, illegal_o}, {31'd0, vecs[i].ill});
            check($sformatf("vec%0d.pc", i),      pc_o,               32'h1000 + 32'(i) * 4);
        end

        // valid_i low loads the bubble.
        valid_i = 1'b0;
        step();
        check_bubble("invalid");
        valid_i = 1'b1;

        // Stall holds addi for three edges while sub waits on instr_i.
        instr_i = ADDI_X1_5;
        pc_i    = 32'h0000_0100;
        step();
        check_addi("load_addi", 32'h0000_0100);
        instr_i = SUB_X3;
        pc_i    = 32'h0000_0104;
        stall   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_addi($sformatf("stall%0d", c), 32'h0000_0100);
        end
        stall = 1'b0;
        step();
        check("release.alu",   {28'd0, ALUCode}, 32'd1);
        check("release.src_b", {31'd0, ALUSrcB}, 32'd0);
        check("release.pc",    pc_o,             32'h0000_0104);

        // Flush alone.
        flush = 1'b1;
        step();
        check_bubble("flush");
        flush = 1'b0;

        // Stall and flush together give the bubble.
        instr_i = ADDI_X1_5;
        pc_i    = 32'h0000_0200;
        step();
        check_addi("pre_sf", 32'h0000_0200);
        stall = 1'b1;
        flush = 1'b1;
        step();
        check_bubble("stall_flush");
        flush = 1'b0;
        stall = 1'b0;

        // Reset asserted while stalled discards the held instruction.
        step();
        check_addi("pre_rst", 32'h0000_0200);
        stall = 1'b1;
        step();
        check_addi("held_rst", 32'h0000_0200);
        rst_n = 1'b0;
        step();
        check_bubble("rst_mid_stall");
        rst_n = 1'b1;
        stall = 1'b0;
        pc_i  = 32'h0000_0300;
        step();
        check_addi("after_rst", 32'h0000_0300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
